// File: rtl/key_loader_pkg.sv
// Shared constants and state encoding for the key loader.
// Imported by key_loader and any parent that sizes its register file.
package key_loader_pkg;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   localparam logic [7:0] KEY_HDR = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      LEN,
      DATA,
      LOADED
   } state_t;

endpackage

// File: rtl/key_loader.sv
// Parses a header/length/data byte stream into an external register file
// and replays the resident key bytes to the encryptor, wrapping at len.
module key_loader #(
   parameter int DEPTH  = key_loader_pkg::DEPTH,
   parameter int ADDR_W = key_loader_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [7:0]        cmd_data,
   output logic              cmd_ready,
   output logic              we,
   output logic [ADDR_W-1:0] wa,
   output logic [7:0]        wd,
   output logic [ADDR_W-1:0] a1,
   input  logic [7:0]        rd1,
   output logic [7:0]        key_byte,
   output logic              key_valid,
   input  logic              key_ack,
   output logic              loaded,
   output logic              err
);

   import key_loader_pkg::*;

   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] IDX_ONE = (ADDR_W)'(1);
   localparam logic [7:0]        MAX_LEN = 8'(DEPTH);

   state_t            state;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   len_m1;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] idx;

   logic acc;
   logic is_hdr;
   logic len_ok;
   logic in_data;
   logic cnt_last;
   logic idx_last;

   assign acc      = cmd_valid & cmd_ready;
   assign is_hdr   = (cmd_data == KEY_HDR);
   assign len_ok   = (cmd_data != 8'd0) && (cmd_data <= MAX_LEN);
   assign in_data  = (state == DATA);
   assign len_m1   = len - LEN_ONE;
   assign cnt_last = ({1'b0, cnt} == len_m1);
   assign idx_last = ({1'b0, idx} == len_m1);

   // Write lands on the acceptance edge, so the write port is combinational.
   assign we       = acc & in_data;
   assign wa       = in_data ? cnt : '0;
   assign wd       = in_data ? cmd_data : 8'd0;
   assign a1       = key_valid ? idx : '0;
   assign key_byte = rd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         len       <= '0;
         cnt       <= '0;
         idx       <= '0;
         cmd_ready <= 1'b0;
         loaded    <= 1'b0;
         key_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         cmd_ready <= 1'b1;
         err       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (acc && is_hdr) state <= LEN;
            end
            LEN: begin
               if (acc) begin
                  if (len_ok) begin
                     len   <= cmd_data[ADDR_W:0];
                     cnt   <= '0;
                     state <= DATA;
                  end else begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (acc) begin
                  cnt <= cnt + IDX_ONE;
                  if (cnt_last) begin
                     state     <= LOADED;
                     idx       <= '0;
                     loaded    <= 1'b1;
                     key_valid <= 1'b1;
                  end
               end
            end
            LOADED: begin
               if (key_ack) idx <= idx_last ? '0 : idx + IDX_ONE;
               // A new header overrides a same-cycle ack.
               if (acc && is_hdr) begin
                  state     <= LEN;
                  idx       <= '0;
                  loaded    <= 1'b0;
                  key_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader with a stream-level reference model
// and an external register file modelled as a plain array.
module tb_key_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'd0;
   logic       cmd_ready;
   logic       we;
   logic [2:0] wa;
   logic [7:0] wd;
   logic [2:0] a1;
   logic [7:0] rd1;
   logic [7:0] key_byte;
   logic       key_valid;
   logic       key_ack = 1'b0;
   logic       loaded;
   logic       err;

   logic [7:0] mem [8];

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   key_loader dut (
      .clock    (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_data (cmd_data),
      .cmd_ready(cmd_ready),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .a1       (a1),
      .rd1      (rd1),
      .key_byte (key_byte),
      .key_valid(key_valid),
      .key_ack  (key_ack),
      .loaded   (loaded),
      .err      (err)
   );

   initial for (int i = 0; i < 8; i++) mem[i] = 8'd0;
   always @(posedge clk) if (we === 1'b1) mem[wa] <= wd;
   assign rd1 = mem[a1];

   always @(posedge clk) if (we === 1'b1) we_cnt++;
   always @(negedge clk) if (err === 1'b1) err_cnt++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Stream-level model: header, length, collected bytes, resident key.
   bit        m_rdy = 0;
   bit        m_err = 0;
   bit        m_rst = 1;
   bit        m_loaded = 0;
   bit        m_want_len = 0;
   bit        m_coll_on = 0;
   int        m_len = 0;
   int        m_ptr = 0;
   logic [7:0] m_coll [$];
   logic [7:0] m_key [$];

   always @(posedge clk) begin
      bit a;
      a = cmd_valid && m_rdy;
      if (reset) begin
         m_rdy = 0; m_err = 0; m_rst = 1; m_loaded = 0;
         m_want_len = 0; m_coll_on = 0; m_ptr = 0; m_len = 0;
         m_coll.delete();
      end else begin
         m_rst = 0;
         m_err = 0;
         if (m_loaded) begin
            if (key_ack) m_ptr = (m_ptr + 1) % m_len;
            if (a && cmd_data == 8'hA5) begin
               m_loaded = 0; m_ptr = 0; m_want_len = 1;
            end
         end else if (m_want_len) begin
            if (a) begin
               m_want_len = 0;
               if (cmd_data >= 1 && cmd_data <= 8) begin
                  m_len = int'(cmd_data);
                  m_coll.delete();
                  m_coll_on = 1;
               end else m_err = 1;
            end
         end else if (m_coll_on) begin
            if (a) begin
               m_coll.push_back(cmd_data);
               if (m_coll.size() == m_len) begin
                  m_key = m_coll;
                  m_loaded = 1; m_ptr = 0; m_coll_on = 0;
               end
            end
         end else if (a && cmd_data == 8'hA5) m_want_len = 1;
         m_rdy = 1;
      end
   end

   always @(negedge clk) begin
      bit e_we;
      e_we = m_coll_on && cmd_valid && m_rdy;
      chk("cmd_ready", cmd_ready, m_rdy);
      chk("we", we, e_we);
      if (e_we) begin
         chk("wa", wa, m_coll.size());
         chk("wd", wd, cmd_data);
      end
      if (m_rst) begin
         chk("wa_rst", wa, 0);
         chk("wd_rst", wd, 0);
      end
      chk("err", err, m_err);
      chk("loaded", loaded, m_loaded);
      chk("key_valid", key_valid, m_loaded);
      chk("a1", a1, m_loaded ? m_ptr : 0);
      if (m_loaded) chk("key_byte", key_byte, m_key[m_ptr]);
   end

   task automatic send(input logic [7:0] b);
      cmd_valid = 1'b1;
      cmd_data  = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [7:0] seen [9];
   logic [7:0] exp45 [4];
   int w0, e0;

   initial begin
      exp45 = '{8'h11, 8'h22, 8'h33, 8'h11};
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      idle(1);

      // Three-byte load
      w0 = we_cnt;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      chk("lit_we3", we_cnt - w0, 3);
      @(negedge clk);
      chk("lit_loaded", loaded, 1);
      chk("lit_a1", a1, 0);
      chk("lit_kb0", key_byte, 8'h11);
      chk("lit_mem0", mem[0], 8'h11);
      chk("lit_mem1", mem[1], 8'h22);
      chk("lit_mem2", mem[2], 8'h33);

      // Ack for four cycles, wrapping at len=3
      @(posedge clk);
      #1 key_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) seen[i] = key_byte;
         @(posedge clk);
         #1;
      end
      key_ack = 1'b0;
      for (int i = 0; i < 4; i++) chk("lit_wrap", seen[i], exp45[i]);

      // Non-header byte while loaded is ignored
      w0 = we_cnt;
      send(8'h77);
      @(negedge clk);
      chk("lit_77_loaded", loaded, 1);
      chk("lit_77_kb", key_byte, 8'h22);
      chk("lit_77_we", we_cnt - w0, 0);

      // Header together with ack: reload wins
      cmd_valid = 1'b1; cmd_data = 8'hA5; key_ack = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0; key_ack = 1'b0;
      @(negedge clk);
      chk("lit_rl_valid", key_valid, 0);
      chk("lit_rl_loaded", loaded, 0);
      send(8'h01); send(8'h5C);
      @(negedge clk);
      chk("lit_5c_loaded", loaded, 1);
      chk("lit_5c_kb", key_byte, 8'h5C);

      // Bad lengths and ignored idle bytes
      e0 = err_cnt; w0 = we_cnt;
      send(8'hA5); send(8'h00);
      idle(2);
      chk("lit_err0", err_cnt - e0, 1);
      chk("lit_err0_we", we_cnt - w0, 0);
      send(8'h3C); send(8'h01); send(8'h02);
      idle(1);
      chk("lit_idle_we", we_cnt - w0, 0);
      send(8'hA5); send(8'h09);
      idle(2);
      chk("lit_err9", err_cnt - e0, 2);
      chk("lit_err9_we", we_cnt - w0, 0);

      // Reset mid-load
      send(8'hA5); send(8'h04); send(8'hAA); send(8'hBB);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);
      chk("lit_rst_loaded", loaded, 0);
      chk("lit_rst_mem0", mem[0], 8'hAA);
      chk("lit_rst_mem1", mem[1], 8'hBB);
      w0 = we_cnt;
      send(8'h11); send(8'h22);
      idle(1);
      chk("lit_rst_we", we_cnt - w0, 0);
      chk("lit_rst_mem0b", mem[0], 8'hAA);

      // Full-depth load with a stalled upstream
      send(8'hA5);
      idle(6);
      send(8'h08);
      for (int i = 0; i < 8; i++) begin
         send(8'(8'h10 * i + 1));
         if (i == 3) idle(5);
      end
      @(negedge clk);
      chk("lit_d8_loaded", loaded, 1);
      chk("lit_d8_mem7", mem[7], 8'h71);
      @(posedge clk);
      #1 key_ack = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk) seen[i] = key_byte;
         @(posedge clk);
         #1;
      end
      key_ack = 1'b0;
      chk("lit_d8_last", seen[7], 8'h71);
      chk("lit_d8_wrap", seen[8], 8'h01);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
